mc_control_fsm: RTL and testbench

- Main control state machine for the multicycle RV32I processor.
- Sequences fetch/decode/execute/memory/writeback over several cycles.
- Drives the immediate-extender select (imm_src), ALU operand muxes, ALU op class and the write enables.
- Sits between the instruction register (op, funct3) and the datapath. It also keeps a retired-instruction counter.

---
 rtl/mc_control_fsm.sv | 175 +++++++++++++++++
 tb/tb_mc_control_fsm.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I main controller: sequences fetch/decode/execute/memory/writeback
// and counts retired instructions.
module mc_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             zero,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       imm_src,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] retired
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R,
    S_EXEC_I, S_ALUWB, S_JAL, S_BRANCH, S_LUI, S_AUIPC
  } state_t;

  state_t state, state_next;
  logic   pc_update, branch, illegal_raw, retire;
  logic   mem_write_raw, ir_write_raw, reg_write_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      retired <= '0;
    end else begin
      state <= state_next;
      if (retire) retired <= retired + 1'b1;
    end
  end

  always_comb begin
    state_next    = state;
    pc_update     = 1'b0;
    branch        = 1'b0;
    illegal_raw   = 1'b0;
    retire        = 1'b0;
    adr_src       = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    case (state)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        pc_update    = 1'b1;
        state_next   = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXEC_R;
          OP_I:              state_next = S_EXEC_I;
          OP_JAL:            state_next = S_JAL;
          OP_BR:             state_next = S_BRANCH;
          OP_LUI:            state_next = S_LUI;
          OP_AUIPC:          state_next = S_AUIPC;
          default: begin
            state_next  = S_FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
        retire        = 1'b1;
        state_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        retire        = 1'b1;
        state_next    = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        retire        = 1'b1;
        state_next    = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        branch     = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_LUI: begin
        result_src    = 2'b11;
        reg_write_raw = 1'b1;
        retire        = 1'b1;
        state_next    = S_FETCH;
      end
      S_AUIPC: begin
        reg_write_raw = 1'b1;
        retire        = 1'b1;
        state_next    = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Write enables are masked by reset combinationally so a reset landing mid-store never writes.
  assign pc_write      = ~reset & (pc_update | (branch & (zero ^ funct3[0])));
  assign mem_write     = ~reset & mem_write_raw;
  assign ir_write      = ~reset & ir_write_raw;
  assign reg_write     = ~reset & reg_write_raw;
  assign illegal_instr = ~reset & illegal_raw;

  always_comb begin
    imm_src = 3'b000;
    case (op)
      OP_STORE:         imm_src = 3'b001;
      OP_BR:            imm_src = 3'b010;
      OP_LUI, OP_AUIPC: imm_src = 3'b011;
      OP_JAL:           imm_src = 3'b100;
      default:          imm_src = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-cycle expected outputs are queued by the
// stimulus process from an instruction-level model and checked by a separate monitor.
module tb_mc_control_fsm;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             zero;
  logic             pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0]       result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0]       imm_src;
  logic [CNT_W-1:0] retired;

  mc_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_src(imm_src), .illegal_instr(illegal_instr), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0] imm_src;
    logic       illegal_instr;
    logic [3:0] retired;
  } vec_t;

  typedef struct {
    vec_t v;
    int   id;
    int   cyc;
  } item_t;

  typedef enum {K_LW, K_SW, K_R, K_I, K_JAL, K_BR, K_LUI, K_AUIPC, K_ILL} kind_t;

  item_t      sb_q[$];
  int         tests = 0;
  int         fails = 0;
  int         cnt   = 0;
  int         instr_id = 0;
  bit         stim_done = 1'b0;

  function automatic kind_t kind_of(input logic [6:0] o);
    case (o)
      7'b0000011: return K_LW;
      7'b0100011: return K_SW;
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b1101111: return K_JAL;
      7'b1100011: return K_BR;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic int latency(input kind_t k);
    case (k)
      K_LW:                 return 5;
      K_SW, K_R, K_I, K_JAL: return 4;
      K_ILL:                return 2;
      default:              return 3;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input kind_t k);
    case (k)
      K_SW:           return 3'b001;
      K_BR:           return 3'b010;
      K_LUI, K_AUIPC: return 3'b011;
      K_JAL:          return 3'b100;
      default:        return 3'b000;
    endcase
  endfunction

  // Expected outputs for cycle c (1-based) of an instruction of kind k.
  function automatic vec_t expect_cycle(input kind_t k, input logic [2:0] f3,
                                        input logic z, input int c, input int rcnt);
    vec_t e = '0;
    e.imm_src = imm_of(k);
    e.retired = rcnt[3:0];
    if (c == 1) begin
      e.ir_write = 1; e.pc_write = 1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
    end else if (c == 2) begin
      e.alu_src_a = 2'b01; e.alu_src_b = 2'b01; e.illegal_instr = (k == K_ILL);
    end else if (c == latency(k)) begin
      case (k)
        K_LW:    begin e.result_src = 2'b01; e.reg_write = 1; end
        K_SW:    begin e.adr_src = 1; e.mem_write = 1; end
        K_R, K_I, K_JAL, K_AUIPC: e.reg_write = 1;
        K_LUI:   begin e.result_src = 2'b11; e.reg_write = 1; end
        K_BR:    begin e.alu_src_a = 2'b10; e.alu_op = 2'b01; e.pc_write = z ^ f3[0]; end
        default: ;
      endcase
    end else if (c == 3) begin
      case (k)
        K_LW, K_SW: begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
        K_R:        begin e.alu_src_a = 2'b10; e.alu_op = 2'b10; end
        K_I:        begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.alu_op = 2'b10; end
        K_JAL:      begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1; end
        default: ;
      endcase
    end else begin
      e.adr_src = 1; // cycle 4 of lw
    end
    return e;
  endfunction

  task automatic push(input vec_t v, input int c);
    item_t it;
    it.v = v; it.id = instr_id; it.cyc = c;
    sb_q.push_back(it);
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic z);
    kind_t k = kind_of(o);
    for (int c = 1; c <= latency(k); c++) begin
      @(posedge clk); #1;
      reset = 1'b0; op = o; funct3 = f3; zero = z;
      push(expect_cycle(k, f3, z, c, cnt), c);
    end
    if (k != K_ILL) cnt = (cnt + 1) % 16;
    instr_id++;
  endtask

  // Store interrupted by a 3-cycle reset starting in its MEMWRITE cycle.
  task automatic run_sw_with_reset();
    vec_t e;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      reset = 1'b0; op = 7'b0100011; funct3 = 3'b010; zero = 1'b0;
      push(expect_cycle(K_SW, 3'b010, 1'b0, c, cnt), c);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    e = '0; e.adr_src = 1; e.imm_src = 3'b001; e.retired = cnt[3:0];
    push(e, 4);
    cnt = 0;
    for (int c = 5; c <= 6; c++) begin
      @(posedge clk); #1;
      e = '0; e.alu_src_b = 2'b10; e.result_src = 2'b10; e.imm_src = 3'b001;
      push(e, c);
    end
    instr_id++;
  endtask

  initial begin : monitor
    item_t it;
    vec_t  act;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        it  = sb_q.pop_front();
        act = '{pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                alu_src_a, alu_src_b, alu_op, imm_src, illegal_instr, retired};
        tests++;
        if (act !== it.v) begin
          fails++;
          $display("FAIL outputs instr %0d cycle %0d: got %h expected %h",
                   it.id, it.cyc, act, it.v);
        end
      end
    end
  end

  initial begin : watchdog
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: stimulus not done, got timeout expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  logic [6:0] legal_ops [8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                7'b1101111, 7'b1100011, 7'b0110111, 7'b0010111};

  initial begin : stimulus
    logic [6:0] o;
    reset = 1'b1; op = 7'b0; funct3 = 3'b0; zero = 1'b0;
    repeat (2) @(posedge clk);
    cnt = 0;
    run_instr(7'b0000011, 3'b010, 1'b0); // lw
    run_instr(7'b0100011, 3'b010, 1'b1); // sw
    run_instr(7'b1100011, 3'b000, 1'b1); // beq taken
    run_instr(7'b1100011, 3'b000, 1'b0); // beq not taken
    run_instr(7'b1100011, 3'b001, 1'b1); // bne not taken
    run_instr(7'b1100011, 3'b001, 1'b0); // bne taken
    run_instr(7'b1101111, 3'b000, 1'b0); // jal
    run_instr(7'b0110111, 3'b000, 1'b0); // lui
    run_instr(7'b0010111, 3'b000, 1'b0); // auipc
    run_instr(7'b0110011, 3'b000, 1'b1); // R
    run_instr(7'b0010011, 3'b000, 1'b0); // I
    run_instr(7'b1111111, 3'b000, 1'b0); // illegal
    run_sw_with_reset();
    for (int i = 0; i < 17; i++) run_instr(7'b0110111, 3'b000, 1'b0); // retired wraps past 15
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) o = 7'($urandom);
      else o = legal_ops[$urandom_range(0, 7)];
      run_instr(o, 3'($urandom), 1'($urandom));
      if ($urandom_range(0, 60) == 0) run_sw_with_reset();
    end
    stim_done = 1'b1;
    repeat (3) @(posedge clk);
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
